// File: rtl/cmd_pkg.sv
// Shared encodings and ASCII constants for the stopwatch command scheduler.
package cmd_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    RUN   = 2'b01,
    CLEAR = 2'b10
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_WAIT  = 2'b10
  } tx_state_t;

  localparam logic [7:0] CMD_RUN  = 8'h72;
  localparam logic [7:0] CMD_STOP = 8'h73;
  localparam logic [7:0] CMD_CLR  = 8'h63;
  localparam logic [7:0] ACK_RUN  = 8'h52;
  localparam logic [7:0] ACK_STOP = 8'h53;
  localparam logic [7:0] ACK_CLR  = 8'h43;
  localparam logic [7:0] ACK_REJ  = 8'h3F;

  // Clear is only accepted from STOP; everything unknown is rejected.
  function automatic logic [7:0] ack_byte(input ctrl_state_t st, input logic [7:0] cmd);
    case (cmd)
      CMD_RUN:  ack_byte = ACK_RUN;
      CMD_STOP: ack_byte = ACK_STOP;
      CMD_CLR:  ack_byte = (st == STOP) ? ACK_CLR : ACK_REJ;
      default:  ack_byte = ACK_REJ;
    endcase
  endfunction

endpackage

// File: rtl/cmd_sched_ctrl_if.sv
// UART rx/tx handshake bundle between the uart pair (master) and the scheduler (slave).
interface cmd_sched_ctrl_if;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_busy;
  logic       i_tx_done;
  logic       o_tx_start;
  logic [7:0] o_tx_data;

  modport master (
    output i_rx_data, i_rx_done, i_tx_busy, i_tx_done,
    input  o_tx_start, o_tx_data
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_busy, i_tx_done,
    output o_tx_start, o_tx_data
  );
endinterface

// File: rtl/ack_tx_seq.sv
// One-entry ack slot plus the start/done handshake that pushes it into the UART transmitter.
module ack_tx_seq
  import cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_byte,
  output logic       o_slot_full,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data
);

  tx_state_t  r_state;
  logic       r_full;
  logic [7:0] r_byte;
  logic       r_tx_start;
  logic [7:0] r_tx_data;

  // Loads only arrive while the slot is empty, which also means the FSM is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= TX_IDLE;
      r_full     <= 1'b0;
      r_byte     <= 8'h00;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      if (i_load) begin
        r_full <= 1'b1;
        r_byte <= i_load_byte;
      end
      case (r_state)
        TX_IDLE: begin
          if (r_full && !i_tx_busy) begin
            r_state    <= TX_START;
            r_tx_start <= 1'b1;
            r_tx_data  <= r_byte;
          end
        end
        TX_START: r_state <= TX_WAIT;
        TX_WAIT: begin
          if (i_tx_done) begin
            r_full  <= 1'b0;
            r_state <= TX_IDLE;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_slot_full = r_full;
  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;

endmodule

// File: rtl/cmd_sched_ctrl.sv
// Merges button edges and UART command bytes into one stream driving the counter run/clear controls.
module cmd_sched_ctrl
  import cmd_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 4,
  parameter bit          ACK_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  cmd_sched_ctrl_if.slave  bus,
  input  logic             btnr,
  input  logic             btnu,
  output logic             o_run_on,
  output logic             o_clr_on,
  output logic             o_overrun
);

  localparam logic [7:0] CLR_LOAD = 8'(CLR_CYCLES);

  ctrl_state_t r_state;
  logic [7:0]  r_cnt;
  logic        r_run_on;
  logic        r_clr_on;
  logic        r_btnr_q;
  logic        r_btnu_q;
  logic        r_rx_valid;
  logic [7:0]  r_rx_byte;
  logic        r_overrun;

  logic        w_btnr_edge;
  logic        w_btnu_edge;
  logic        w_slot_full;
  logic        w_service;
  logic        w_ack_load;
  logic [7:0]  w_ack_byte;
  logic        w_tx_start;
  logic [7:0]  w_tx_data;

  assign w_btnr_edge = btnr & ~r_btnr_q;
  assign w_btnu_edge = btnu & ~r_btnu_q;
  // Any button edge takes the cycle, even one the current state ignores.
  assign w_service   = r_rx_valid & ~(w_btnr_edge | w_btnu_edge) & (r_state != CLEAR)
                       & (~w_slot_full | ~ACK_EN);
  assign w_ack_load  = w_service & ACK_EN;
  assign w_ack_byte  = ack_byte(r_state, r_rx_byte);

  // Button history for one-shot edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btnr_q <= 1'b0;
      r_btnu_q <= 1'b0;
    end else begin
      r_btnr_q <= btnr;
      r_btnu_q <= btnu;
    end
  end

  // One-deep rx holding register; a byte arriving while it is occupied is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= bus.i_rx_done & r_rx_valid;
      if (w_service) begin
        r_rx_valid <= 1'b0;
      end else if (bus.i_rx_done && !r_rx_valid) begin
        r_rx_valid <= 1'b1;
        r_rx_byte  <= bus.i_rx_data;
      end
    end
  end

  // Control FSM; outputs are updated alongside the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= STOP;
      r_cnt    <= 8'd0;
      r_run_on <= 1'b0;
      r_clr_on <= 1'b0;
    end else begin
      case (r_state)
        STOP: begin
          if (w_btnr_edge || (w_service && r_rx_byte == CMD_RUN)) begin
            r_state  <= RUN;
            r_run_on <= 1'b1;
          end else if (w_btnu_edge || (w_service && r_rx_byte == CMD_CLR)) begin
            r_state  <= CLEAR;
            r_cnt    <= CLR_LOAD;
            r_clr_on <= 1'b1;
          end
        end
        RUN: begin
          if (w_btnr_edge || (w_service && r_rx_byte == CMD_STOP)) begin
            r_state  <= STOP;
            r_run_on <= 1'b0;
          end
        end
        CLEAR: begin
          if (r_cnt == 8'd1) begin
            r_state  <= STOP;
            r_cnt    <= 8'd0;
            r_clr_on <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state  <= STOP;
          r_cnt    <= 8'd0;
          r_run_on <= 1'b0;
          r_clr_on <= 1'b0;
        end
      endcase
    end
  end

  ack_tx_seq u_ack_tx_seq (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_ack_load),
    .i_load_byte (w_ack_byte),
    .o_slot_full (w_slot_full),
    .i_tx_busy   (bus.i_tx_busy),
    .i_tx_done   (bus.i_tx_done),
    .o_tx_start  (w_tx_start),
    .o_tx_data   (w_tx_data)
  );

  assign bus.o_tx_start = w_tx_start & ACK_EN;
  assign bus.o_tx_data  = w_tx_data;
  assign o_run_on       = r_run_on;
  assign o_clr_on       = r_clr_on;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_cmd_sched_ctrl.sv
// Directed and randomized bench for cmd_sched_ctrl against a cycle-level behavioural model.
module tb_cmd_sched_ctrl;

  localparam int CLR = 4;

  logic clk;
  logic reset;
  logic btnr;
  logic btnu;
  logic o_run_on;
  logic o_clr_on;
  logic o_overrun;

  cmd_sched_ctrl_if bus ();

  cmd_sched_ctrl #(.CLR_CYCLES(CLR), .ACK_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .btnr      (btnr),
    .btnu      (btnu),
    .o_run_on  (o_run_on),
    .o_clr_on  (o_clr_on),
    .o_overrun (o_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int clr_seen = 0;
  int ovr_seen = 0;
  int start_seen = 0;

  // Reference model: what the outputs should be in the current cycle
  bit         m_run;
  int         m_clr_left;
  bit         m_ovr;
  logic [7:0] m_pend[$];
  bit         m_prev_r, m_prev_u;
  bit         m_slot_full;
  logic [7:0] m_slot_byte;
  bit         m_start_now;
  bit         m_waiting;
  logic [7:0] m_txd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_clr_left = 0; m_ovr = 1'b0; m_pend.delete();
    m_prev_r = 1'b0; m_prev_u = 1'b0; m_slot_full = 1'b0; m_slot_byte = 8'h00;
    m_start_now = 1'b0; m_waiting = 1'b0; m_txd = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_run"}, 32'(o_run_on), 32'd0);
    chk({tag, "_clr"}, 32'(o_clr_on), 32'd0);
    chk({tag, "_ovr"}, 32'(o_overrun), 32'd0);
    chk({tag, "_txs"}, 32'(bus.o_tx_start), 32'd0);
    chk({tag, "_txd"}, 32'(bus.o_tx_data), 32'd0);
  endtask

  // One clock: compare at negedge, advance the model from this cycle's inputs.
  task automatic tick();
    bit er, eu, svc, had_pend, n_run, n_ovr, n_slot_full, n_start, n_wait;
    int n_clr;
    logic [7:0] cmd, ack, n_slot_byte, n_txd;
    @(negedge clk);
    chk("run_on", 32'(o_run_on), 32'(m_run));
    chk("clr_on", 32'(o_clr_on), 32'(m_clr_left > 0));
    chk("overrun", 32'(o_overrun), 32'(m_ovr));
    chk("tx_start", 32'(bus.o_tx_start), 32'(m_start_now));
    chk("tx_data", 32'(bus.o_tx_data), 32'(m_txd));
    if (o_clr_on) clr_seen++;
    if (o_overrun) ovr_seen++;
    if (bus.o_tx_start) start_seen++;
    er = btnr & ~m_prev_r;
    eu = btnu & ~m_prev_u;
    had_pend = (m_pend.size() != 0);
    svc = had_pend && !er && !eu && (m_clr_left == 0) && !m_slot_full;
    n_run = m_run; n_clr = m_clr_left;
    n_slot_full = m_slot_full; n_slot_byte = m_slot_byte;
    n_start = m_slot_full && !m_start_now && !m_waiting && !bus.i_tx_busy;
    n_wait = m_waiting;
    if (m_start_now) n_wait = 1'b1;
    else if (m_waiting && bus.i_tx_done) begin n_wait = 1'b0; n_slot_full = 1'b0; end
    n_txd = n_start ? m_slot_byte : m_txd;
    if (m_clr_left > 0) n_clr = m_clr_left - 1;
    else if (er) n_run = !m_run;
    else if (eu) begin
      if (!m_run) n_clr = CLR;
    end else if (svc) begin
      cmd = m_pend[0];
      ack = 8'h3F;
      if (cmd == 8'h72) begin n_run = 1'b1; ack = 8'h52; end
      else if (cmd == 8'h73) begin n_run = 1'b0; ack = 8'h53; end
      else if (cmd == 8'h63 && !m_run) begin n_clr = CLR; ack = 8'h43; end
      n_slot_full = 1'b1; n_slot_byte = ack;
    end
    n_ovr = bus.i_rx_done && had_pend;
    @(posedge clk);
    #1;
    if (svc) void'(m_pend.pop_front());
    if (bus.i_rx_done && !had_pend) m_pend.push_back(bus.i_rx_data);
    m_run = n_run; m_clr_left = n_clr; m_ovr = n_ovr;
    m_slot_full = n_slot_full; m_slot_byte = n_slot_byte;
    m_start_now = n_start; m_waiting = n_wait; m_txd = n_txd;
    m_prev_r = btnr; m_prev_u = btnu;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
  endtask

  // Waits (bounded) for a tx start, checks its byte, then completes the transfer.
  task automatic serve_tx(input logic [7:0] exp_b);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.o_tx_start) seen = 1'b1;
      else tick();
    end
    chk("tx_start_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("ack_byte", 32'(bus.o_tx_data), 32'(exp_b));
      tick();
      tick();
      bus.i_tx_done = 1'b1;
      tick();
    end
  endtask

  // Asserts reset between clock edges and expects outputs to clear at once.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    btnr = 1'b0; btnu = 1'b0;
    bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0; bus.i_tx_busy = 1'b0;
    #2;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    reset = 1'b1; btnr = 1'b0; btnu = 1'b0;
    bus.i_rx_data = 8'h00; bus.i_rx_done = 1'b0;
    bus.i_tx_busy = 1'b0; bus.i_tx_done = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    // btnr held: single rise one cycle after the edge, no ack
    btnr = 1'b1;
    tick();
    chk("btnr_rise", 32'(o_run_on), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("btnr_held", 32'(o_run_on), 32'd1);
    chk("btn_no_ack", 32'(start_seen), 32'd0);
    btnr = 1'b0; tick();
    btnr = 1'b1; tick();
    btnr = 1'b0; tick();
    chk("btnr_stop", 32'(o_run_on), 32'd0);

    // rx 'c' in STOP: CLR cycles of clear, ack 'C', then slot free for 's'
    clr_seen = 0;
    send_rx(8'h63);
    serve_tx(8'h43);
    for (int i = 0; i < 6; i++) tick();
    chk("clr_len", 32'(clr_seen), 32'(CLR));
    chk("clr_done", 32'(o_clr_on), 32'd0);
    send_rx(8'h73);
    serve_tx(8'h53);
    chk("stop_noop", 32'(o_run_on), 32'd0);

    // RUN: 'c' rejected, unknown rejected, 's' stops
    btnr = 1'b1; tick();
    btnr = 1'b0; tick();
    send_rx(8'h63);
    serve_tx(8'h3F);
    chk("run_clr_rej", 32'(o_run_on), 32'd1);
    send_rx(8'h78);
    serve_tx(8'h3F);
    send_rx(8'h73);
    serve_tx(8'h53);
    chk("run_s_stop", 32'(o_run_on), 32'd0);

    // btnr edge and rx 'r' together: button first, then 'r' as a no-op
    btnr = 1'b1;
    send_rx(8'h72);
    chk("arb_btn_first", 32'(o_run_on), 32'd1);
    serve_tx(8'h52);
    btnr = 1'b0; tick();
    chk("arb_still_run", 32'(o_run_on), 32'd1);
    btnr = 1'b1; tick();
    btnr = 1'b0; tick();

    // tx busy: first served, second pending, third dropped
    ovr_seen = 0;
    bus.i_tx_busy = 1'b1;
    send_rx(8'h72);
    for (int i = 0; i < 4; i++) tick();
    send_rx(8'h73);
    for (int i = 0; i < 4; i++) tick();
    send_rx(8'h63);
    for (int i = 0; i < 3; i++) tick();
    chk("overrun_cnt", 32'(ovr_seen), 32'd1);
    chk("busy_run", 32'(o_run_on), 32'd1);
    bus.i_tx_busy = 1'b0;
    serve_tx(8'h52);
    serve_tx(8'h53);
    chk("pend_served", 32'(o_run_on), 32'd0);

    // Reset during TX_WAIT
    send_rx(8'h72);
    for (int i = 0; i < 10 && !bus.o_tx_start; i++) tick();
    tick();
    async_reset("rst_txwait");
    start_seen = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("no_tx_after_rst", 32'(start_seen), 32'd0);

    // Reset during CLEAR, then a normal restart
    send_rx(8'h63);
    tick();
    chk("clr_mid", 32'(o_clr_on), 32'd1);
    async_reset("rst_clear");
    start_seen = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("no_tx_after_rst2", 32'(start_seen), 32'd0);
    btnr = 1'b1; tick();
    chk("restart_run", 32'(o_run_on), 32'd1);
    btnr = 1'b0; tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) btnr = ~btnr;
      if ($urandom_range(0, 11) == 0) btnu = ~btnu;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: rb = 8'h72;
          1: rb = 8'h73;
          2: rb = 8'h63;
          3: rb = 8'h78;
          default: rb = 8'($urandom);
        endcase
        bus.i_rx_data = rb;
        bus.i_rx_done = 1'b1;
      end
      bus.i_tx_busy = ($urandom_range(0, 3) == 0);
      bus.i_tx_done = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_sched_ctrl.md
Name: cmd_sched_ctrl

Overview:
Command scheduler for the stopwatch/upcounter datapath. Merges two command sources, raw buttons and UART rx bytes, into one arbitrated command stream, then sequences the counter's run/clear controls. Returns a one-byte acknowledgement for every UART-sourced command through the UART tx start/done handshake. Sits between the uart_rx/uart_tx pair and the counter core.

Parameters:
CLR_CYCLES, 4, number of cycles o_clr_on stays high per clear; legal range 1..255.
ACK_EN, 1, 1 = send acks on UART tx; 0 = o_tx_start tied 0 and the ack slot is never loaded.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
i_rx_data  in  8  received byte; valid when i_rx_done=1
i_rx_done  in  1  1-cycle pulse, byte received
btnr  in  1  run/stop button, level (debounced upstream)
btnu  in  1  clear button, level (debounced upstream)
i_tx_busy  in  1  UART tx is transmitting
i_tx_done  in  1  1-cycle pulse, tx byte finished
o_tx_start  out  1  1-cycle pulse, start tx of o_tx_data
o_tx_data  out  8  ack byte; held stable from o_tx_start until i_tx_done
o_run_on  out  1  counter enable
o_clr_on  out  1  counter clear
o_overrun  out  1  1-cycle pulse, rx byte dropped

Behaviour:
- Reset: all outputs 0, o_tx_data=0. State STOP. Pending rx register, ack slot and button history registers all cleared.
- Reset mid-operation (including mid-tx or mid-clear) aborts everything. No further o_tx_start occurs until a new command arrives.
- Button events:
  - Rising edge = btn high this cycle and low the previous registered cycle. One event per press.
  - A held button produces no repeats.
- Rx pending register (1-deep):
  - i_rx_done with register empty: byte captured, valid from the next cycle.
  - i_rx_done with register full: new byte dropped, o_overrun pulses 1 cycle in the next cycle.
- Arbitration (evaluated every cycle):
  - Button event beats a pending rx command.
  - A losing rx command stays pending and is evaluated the next cycle.
  - btnr and btnu edges in the same cycle: btnr wins; the btnu edge is discarded.
- Rx command service condition: state != CLEAR and ack slot empty (or ACK_EN=0). Otherwise the command stays pending.
- Control FSM states: STOP, RUN, CLEAR.
  - STOP: btnr edge or 'r' -> RUN. btnu edge or 'c' -> CLEAR (load counter with CLR_CYCLES). 's' -> stays STOP (no-op, accepted).
  - RUN: btnr edge or 's' -> STOP. 'r' -> no-op, accepted. 'c' -> rejected, no state change. btnu edge -> ignored.
  - CLEAR: count down each cycle; at count 1 -> STOP. Button edges ignored; rx commands held.
  - Any other byte value: rejected, no state change.
- Outputs are registered from state:
  - o_run_on = (state==RUN).
  - o_clr_on = (state==CLEAR), high for exactly CLR_CYCLES consecutive cycles.
- Latency:
  - Button edge at sampled cycle N -> state and outputs change at cycle N+1.
  - i_rx_done at cycle N (nothing contending) -> command serviced at N+1 -> outputs change at N+2.
- Ack:
  - Each serviced rx command loads the ack slot at service time.
  - Ack byte: 'R' for 'r', 'S' for 's', 'C' for 'c', '?' for rejected.
  - Button commands produce no ack.
- Tx sequencer states: TX_IDLE, TX_START, TX_WAIT.
  - TX_IDLE: slot full and i_tx_busy=0 -> TX_START.
  - TX_START: o_tx_start=1 for 1 cycle -> TX_WAIT.
  - TX_WAIT: i_tx_done -> slot emptied, back to TX_IDLE.
  - The slot empties the cycle after i_tx_done, so the next rx command can be serviced that cycle.
  - i_tx_done outside TX_WAIT is ignored.

Decomposition:
- Shared package cmd_pkg holds:
  - Control state encodings: STOP=2'b00, RUN=2'b01, CLEAR=2'b10.
  - Tx state encodings.
  - ASCII constants for the command bytes ('r', 's', 'c') and ack bytes ('R', 'S', 'C', '?').
- One sub-module, ack_tx_seq: ack slot plus tx handshake FSM. Interface: load pulse, load byte, slot_full, plus the tx ports.
- Edge detection, arbitration and the control FSM stay in cmd_sched_ctrl.

Test Plan:
- Reset, then btnr held high 10 cycles -> o_run_on rises 1 cycle after the edge and stays 1. No toggle while held. o_tx_start stays 0.
- In STOP, i_rx_done with 0x63 ('c'), CLR_CYCLES=4 -> o_clr_on high exactly 4 cycles starting 2 cycles after the rx pulse, then STOP. One o_tx_start with o_tx_data=0x43; after i_tx_done the slot is free.
- In RUN, rx 'c' (0x63) -> o_run_on stays 1 and ack 0x3F. Then rx 'x' -> ack 0x3F. Then rx 's' -> o_run_on falls and ack 0x53.
- Same-cycle btnr edge and rx 'r' in STOP -> button served first (RUN). The 'r' is served next cycle as a no-op with ack 0x52, so o_run_on remains 1.
- i_tx_busy held 1 while three rx bytes arrive: 1st serviced, 2nd pending, 3rd dropped with o_overrun pulse. After i_tx_done the 2nd is serviced and acked.
- Reset asserted during TX_WAIT and during CLEAR -> outputs 0 immediately (async). No o_tx_start after release. The next btnr edge restarts RUN normally.
